fpu_ss_writeback: RTL and testbench
===================================

// Module: fpu_ss_writeback
// PURPOSE
//  Writeback stage of the FPU subsystem. It sits downstream of the FPnew core and the memory-result path.
//  - Merges FPnew results (tagged with fpu_tag_t) and load results (tagged with mem_metadata_t).
//  - Produces FP register-file writes and fflags updates.
//  - Produces a buffered, in-order cv-x-if result stream toward the core.
//  - Load results cannot be back-pressured, so they have priority over FPU results.
// PARAMETERS
//  FIFO_DEPTH  4  result FIFO entries; power of two, >=2
//  X_ID_WIDTH  4  instruction id width; equals fpu_ss_pkg::X_ID_WIDTH
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   reset; synchronous, active-high
//  fpu_res_valid_i   in   1   FPnew result valid
//  fpu_res_ready_o   out  1   FPnew result ready
//  fpu_res_i         in   32  FPnew result data
//  fpu_tag_i         in   10  fpu_tag_t {addr, rd_is_fp, id}
//  fpu_status_i      in   5   FPnew exception flags {NV,DZ,OF,UF,NX}
//  mem_res_valid_i   in   1   load result valid; no ready exists
//  mem_res_rdata_i   in   32  load data
//  mem_meta_i        in   10  mem_metadata_t {id, rd, we}
//  fpr_we_o          out  1   FP regfile write enable
//  fpr_waddr_o       out  5   FP regfile write address
//  fpr_wdata_o       out  32  FP regfile write data
//  fflags_we_o       out  1   fflags accumulate strobe
//  fflags_o          out  5   flags to OR into fcsr.fflags
//  x_result_valid_o  out  1   cv-x-if result valid
//  x_result_ready_i  in   1   cv-x-if result ready
//  x_result_o        out  -   fpu_ss_pkg::x_result_t
//  overflow_o        out  1   sticky: a load result was dropped
// BEHAVIOUR
//  Reset
//  - Every output register clears to 0: fpr_*, fflags_*, overflow_o and all FIFO state.
//  - While rst_i is high, x_result_valid_o=0 and fpu_res_ready_o=0.
//  - Reset mid-operation flushes all FIFO entries. Nothing is written to the regfile that cycle.
//  FPU acceptance
//  - fpu_res_ready_o = !mem_res_valid_i && (count < FIFO_DEPTH). A pop in the same cycle does not raise ready.
//  - FPU accept = fpu_res_valid_i && fpu_res_ready_o.
//  - Load accept = mem_res_valid_i, every cycle. A load always wins the regfile port.
//  Regfile and fflags (registered, 1-cycle latency)
//  - On FPU accept with rd_is_fp=1, the next cycle drives fpr_we_o=1, fpr_waddr_o=tag.addr, fpr_wdata_o=fpu_res_i.
//  - On load accept with mem_meta_i.we=1, the next cycle drives fpr_we_o=1, fpr_waddr_o=meta.rd, fpr_wdata_o=rdata.
//  - On FPU accept, the next cycle drives fflags_we_o=1 and fflags_o=fpu_status_i. Both are single-cycle pulses.
//  - At most one source is accepted per cycle, so there is no port conflict.
//  FIFO push (one push per cycle maximum)
//  - FPU accept pushes {id=tag.id, data=fpu_res_i, rd=tag.addr, we=!tag.rd_is_fp}.
//  - Load accept pushes {id=meta.id, data=0, rd=meta.rd, we=0}.
//  - Every push sets ecswe=0, ecsdata=0, exc=0, exccode=0.
//  FIFO output and pop
//  - x_result_valid_o = (count != 0). x_result_o is the head entry, read combinationally.
//  - Pop on x_result_valid_o && x_result_ready_i. The output is stable while valid && !ready.
//  - Order is strictly push order. The pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//  - count is log2(FIFO_DEPTH)+1 bits.
//  Simultaneous events and boundaries
//  - Push and pop in the same cycle: count is unchanged. Push when count==FIFO_DEPTH is legal only with a same-cycle pop.
//  - Load push with count==FIFO_DEPTH and no pop: the entry is dropped. The FP regfile write still happens.
//  - overflow_o is set in that case and stays set until rst_i.
//  - Empty FIFO: a push appears at x_result_o on the next cycle. There is no same-cycle bypass.
// TESTING
//  Single FP op: fpu valid, tag={addr=3, rd_is_fp=1, id=2}, res=0x3F800000, status=0x01
//   -> next cycle fpr_we=1, waddr=3, wdata=0x3F800000, fflags_we=1, fflags=0x01.
//   -> x_result {id=2, we=0} valid that cycle.
//  Int-dest op (fcvt/feq): tag={addr=10, rd_is_fp=0, id=5}, res=0x1
//   -> fpr_we stays 0; x_result {id=5, rd=10, data=0x1, we=1}.
//  Collision: mem valid {id=1, rd=7, we=1, rdata=0xDEADBEEF} and fpu valid in the same cycle
//   -> fpu_ready=0; fpr write rd=7 first; FPU result written the following cycle.
//   -> x_result order is id1, then the FPU id.
//  Backpressure: x_result_ready=0, push 4 FPU results
//   -> count=4 and fpu_ready=0; the 5th waits.
//   -> raising ready drains the entries in order, 1 per cycle, and the 5th is then accepted.
//  Overflow: FIFO full, ready=0, load valid
//   -> the fpr write still happens; overflow_o=1 and stays 1; the FIFO contents are unchanged.
//  Reset mid-stream: 3 entries queued, rst_i pulsed 1 cycle
//   -> next cycle x_result_valid=0, count=0, all strobes 0, overflow_o=0.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared types for the FPU subsystem writeback path
package fpu_ss_pkg;

  parameter int X_ID_WIDTH = 4;

  // FPnew operation tag: destination address, FP-vs-integer destination, instruction id
  typedef struct packed {
    logic [4:0]            addr;
    logic                  rd_is_fp;
    logic [X_ID_WIDTH-1:0] id;
  } fpu_tag_t;

  // Load metadata: instruction id, FP destination register, regfile write enable
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
  } mem_metadata_t;

  // cv-x-if result packet returned to the core
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            ecswe;
    logic [5:0]            ecsdata;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

endpackage

// File: rtl/fpu_ss_writeback.sv
// rtl/fpu_ss_writeback.sv - FPU subsystem writeback: regfile/fflags writes and in-order result FIFO
//
// Merges FPnew results and load results. Loads cannot be stalled, so they
// take the regfile port and block FPU acceptance in the same cycle.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   fpu_res_*/fpu_tag_i/fpu_status_i  FPnew result handshake and payload
//   mem_res_valid_i/rdata/meta        load result (no ready)
//   fpr_we_o/waddr/wdata              registered FP regfile write port
//   fflags_we_o/fflags_o              registered fflags accumulate pulse
//   x_result_valid_o/ready_i/x_result_o  buffered in-order result stream
//   overflow_o                        sticky: a load result was dropped at a full FIFO
module fpu_ss_writeback
  import fpu_ss_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_ID_WIDTH = fpu_ss_pkg::X_ID_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fpu_res_valid_i,
  output logic          fpu_res_ready_o,
  input  logic [31:0]   fpu_res_i,
  input  fpu_tag_t      fpu_tag_i,
  input  logic [4:0]    fpu_status_i,
  input  logic          mem_res_valid_i,
  input  logic [31:0]   mem_res_rdata_i,
  input  mem_metadata_t mem_meta_i,
  output logic          fpr_we_o,
  output logic [4:0]    fpr_waddr_o,
  output logic [31:0]   fpr_wdata_o,
  output logic          fflags_we_o,
  output logic [4:0]    fflags_o,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output logic          overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  x_result_t             fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic                  full;
  logic                  fpu_accept;
  logic                  pop;
  logic                  push;
  logic                  dropped;
  logic [X_ID_WIDTH-1:0] push_id;
  x_result_t             push_entry;

  assign full             = (count == DEPTH_C);
  // Ready looks only at the current occupancy; a same-cycle pop never opens it.
  assign fpu_res_ready_o  = !rst_i && !mem_res_valid_i && (count < DEPTH_C);
  assign fpu_accept       = fpu_res_valid_i && fpu_res_ready_o;
  assign x_result_valid_o = !rst_i && (count != '0);
  assign x_result_o       = fifo_mem[rd_ptr];
  assign pop              = x_result_valid_o && x_result_ready_i;
  // A full FIFO can only take a push if the head leaves in the same cycle.
  assign push             = (fpu_accept || mem_res_valid_i) && (!full || pop);
  // Only a load can arrive at a full FIFO (FPU ready is low then), so only loads drop.
  assign dropped          = mem_res_valid_i && full && !pop;
  assign push_id          = mem_res_valid_i ? mem_meta_i.id : fpu_tag_i.id;

  always_comb begin
    push_entry    = '0;
    push_entry.id = push_id;
    if (mem_res_valid_i) begin
      push_entry.rd = mem_meta_i.rd;
    end else begin
      push_entry.data = fpu_res_i;
      push_entry.rd   = fpu_tag_i.addr;
      // Integer-destination ops (fcvt/feq...) return their result to the core's regfile.
      push_entry.we   = !fpu_tag_i.rd_is_fp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fpr_we_o    <= 1'b0;
      fpr_waddr_o <= '0;
      fpr_wdata_o <= '0;
      fflags_we_o <= 1'b0;
      fflags_o    <= '0;
      overflow_o  <= 1'b0;
    end else begin
      // Loads own the regfile port; the FPU is never accepted in the same cycle.
      if (mem_res_valid_i) begin
        fpr_we_o    <= mem_meta_i.we;
        fpr_waddr_o <= mem_meta_i.rd;
        fpr_wdata_o <= mem_res_rdata_i;
      end else if (fpu_accept) begin
        fpr_we_o    <= fpu_tag_i.rd_is_fp;
        fpr_waddr_o <= fpu_tag_i.addr;
        fpr_wdata_o <= fpu_res_i;
      end else begin
        fpr_we_o    <= 1'b0;
      end

      fflags_we_o <= fpu_accept;
      fflags_o    <= fpu_accept ? fpu_status_i : 5'd0;
      overflow_o  <= overflow_o | dropped;

      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ss_writeback.sv
// tb/tb_fpu_ss_writeback.sv - scoreboard bench for fpu_ss_writeback
module tb_fpu_ss_writeback;
  import fpu_ss_pkg::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fpu_res_valid_i = 1'b0;
  logic          fpu_res_ready_o;
  logic [31:0]   fpu_res_i = '0;
  fpu_tag_t      fpu_tag_i = '0;
  logic [4:0]    fpu_status_i = '0;
  logic          mem_res_valid_i = 1'b0;
  logic [31:0]   mem_res_rdata_i = '0;
  mem_metadata_t mem_meta_i = '0;
  logic          fpr_we_o;
  logic [4:0]    fpr_waddr_o;
  logic [31:0]   fpr_wdata_o;
  logic          fflags_we_o;
  logic [4:0]    fflags_o;
  logic          x_result_valid_o;
  logic          x_result_ready_i = 1'b0;
  x_result_t     x_result_o;
  logic          overflow_o;

  fpu_ss_writeback #(.FIFO_DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .fpu_res_valid_i(fpu_res_valid_i), .fpu_res_ready_o(fpu_res_ready_o),
    .fpu_res_i(fpu_res_i), .fpu_tag_i(fpu_tag_i), .fpu_status_i(fpu_status_i),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_rdata_i(mem_res_rdata_i), .mem_meta_i(mem_meta_i),
    .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o),
    .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
    .x_result_o(x_result_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Expected result stream, oldest first. An entry is appended in the cycle it is
  // presented to the DUT; push_pending marks that it is not yet visible at the output.
  x_result_t   sb_q[$];
  int          push_pending = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        exp_we = 1'b0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_fw = 1'b0;
  logic [4:0]  exp_ff = '0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("x_valid", x_result_valid_o, ((sb_q.size() - push_pending) != 0));
      if (x_result_valid_o && x_result_ready_i) begin
        chk("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("x_result", x_result_o, sb_q.pop_front());
      end
    end
  end

  task automatic step(input logic fv, input fpu_tag_t tg, input logic [31:0] res,
                      input logic [4:0] st, input logic mv, input mem_metadata_t mm,
                      input logic [31:0] rdata, input logic xr, output logic acc);
    x_result_t e;
    logic      exp_ready;
    logic      pop;
    @(posedge clk); #1;
    push_pending = 0;
    chk("fpr_we", fpr_we_o, exp_we);
    if (exp_we) begin
      chk("fpr_waddr", fpr_waddr_o, exp_waddr);
      chk("fpr_wdata", fpr_wdata_o, exp_wdata);
    end
    chk("fflags_we", fflags_we_o, exp_fw);
    if (exp_fw) chk("fflags", fflags_o, exp_ff);
    chk("overflow", overflow_o, exp_ovf);

    fpu_res_valid_i = fv; fpu_tag_i = tg; fpu_res_i = res; fpu_status_i = st;
    mem_res_valid_i = mv; mem_meta_i = mm; mem_res_rdata_i = rdata;
    x_result_ready_i = xr;
    #1;
    exp_ready = !mv && (sb_q.size() < DEPTH);
    chk("fpu_ready", fpu_res_ready_o, exp_ready);
    acc = fv && exp_ready;
    pop = (sb_q.size() != 0) && xr;

    exp_we = 1'b0;
    if (mv) begin
      exp_we = mm.we; exp_waddr = mm.rd; exp_wdata = rdata;
    end else if (acc) begin
      exp_we = tg.rd_is_fp; exp_waddr = tg.addr; exp_wdata = res;
    end
    exp_fw = acc;
    exp_ff = st;

    e = '0;
    if (mv) begin
      e.id = mm.id; e.rd = mm.rd;
      if (sb_q.size() == DEPTH && !pop) exp_ovf = 1'b1;
      else begin sb_q.push_back(e); push_pending = 1; end
    end else if (acc) begin
      e.id = tg.id; e.data = res; e.rd = tg.addr; e.we = !tg.rd_is_fp;
      sb_q.push_back(e); push_pending = 1;
    end
  endtask

  task automatic idle(input logic xr, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, '0, xr, a);
  endtask

  task automatic fpu_op(input logic [4:0] addr, input logic fp, input logic [3:0] id,
                        input logic [31:0] res, input logic [4:0] st, input logic xr, output logic acc);
    fpu_tag_t t;
    t.addr = addr; t.rd_is_fp = fp; t.id = id;
    step(1'b1, t, res, st, 1'b0, '0, '0, xr, acc);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; fpu_res_valid_i = 1'b1; mem_res_valid_i = 1'b0; x_result_ready_i = 1'b1;
    #1;
    chk("rst_fpu_ready", fpu_res_ready_o, 0);
    chk("rst_x_valid", x_result_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; fpu_res_valid_i = 1'b0; x_result_ready_i = 1'b0;
    sb_q.delete(); push_pending = 0;
    exp_we = 1'b0; exp_fw = 1'b0; exp_ovf = 1'b0;
    #1;
    chk("rst_fpr_we", fpr_we_o, 0);
    chk("rst_fpr_waddr", fpr_waddr_o, 0);
    chk("rst_fpr_wdata", fpr_wdata_o, 0);
    chk("rst_fflags_we", fflags_we_o, 0);
    chk("rst_fflags", fflags_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_x_valid_after", x_result_valid_o, 0);
  endtask

  initial begin
    logic          a;
    int            tries;
    fpu_tag_t      t;
    mem_metadata_t m;

    do_reset();

    // Single FP op, then integer-destination op
    fpu_op(5'd3, 1'b1, 4'd2, 32'h3F80_0000, 5'h01, 1'b0, a);
    chk("single_accept", a, 1);
    fpu_op(5'd10, 1'b0, 4'd5, 32'h1, 5'h00, 1'b0, a);
    idle(1'b1, 4);

    // Load and FPU collide: load wins, FPU retries next cycle
    t.addr = 5'd4; t.rd_is_fp = 1'b1; t.id = 4'd6;
    m.id = 4'd1; m.rd = 5'd7; m.we = 1'b1;
    step(1'b1, t, 32'h4000_0000, 5'h04, 1'b1, m, 32'hDEAD_BEEF, 1'b1, a);
    chk("collision_blocked", a, 0);
    step(1'b1, t, 32'h4000_0000, 5'h04, 1'b0, '0, '0, 1'b1, a);
    chk("collision_retry", a, 1);
    idle(1'b1, 4);

    // Backpressure: four fill the FIFO, the fifth waits until space frees
    for (int i = 0; i < 4; i++) fpu_op(5'(i + 1), 1'b1, 4'(i), 32'h100 + 32'(i), 5'(i), 1'b0, a);
    fpu_op(5'd20, 1'b1, 4'd4, 32'h104, 5'h10, 1'b0, a);
    chk("fifth_blocked", a, 0);
    tries = 0;
    do begin
      fpu_op(5'd20, 1'b1, 4'd4, 32'h104, 5'h10, 1'b1, a);
      tries++;
    end while (!a && tries < 10);
    chk("fifth_accepted", a, 1);
    idle(1'b1, 6);

    // Overflow: full FIFO, no ready, load arrives
    for (int i = 0; i < 4; i++) fpu_op(5'(i + 8), 1'b0, 4'(i + 8), 32'hA0 + 32'(i), 5'h02, 1'b0, a);
    m.id = 4'd9; m.rd = 5'd12; m.we = 1'b1;
    step(1'b0, '0, '0, '0, 1'b1, m, 32'h1234_5678, 1'b0, a);
    idle(1'b0, 3);
    idle(1'b1, 6);

    // Reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) fpu_op(5'(i), 1'b1, 4'(i + 3), 32'h55 + 32'(i), 5'h08, 1'b0, a);
    do_reset();
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] r10;
      r10 = 10'($urandom);
      t = r10;
      r10 = 10'($urandom);
      m = r10;
      step($urandom_range(0, 9) < 6, t, $urandom, 5'($urandom), $urandom_range(0, 9) < 3,
           m, $urandom, $urandom_range(0, 9) < 5, a);
    end
    idle(1'b1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
